// File: rtl/data_mem_ws_if.sv
// Bus bundle for the wait-state data memory: request side driven by the
// MEM stage (master), response side driven by the memory (slave).
interface data_mem_ws_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] adr;
    logic [31:0]       data_in;
    logic [1:0]        size;
    logic              MEM_R_EN;
    logic              MEM_W_EN;
    logic [31:0]       DATA;
    logic              ready;
    logic              err;

    modport master (
        output adr, data_in, size, MEM_R_EN, MEM_W_EN,
        input  DATA, ready, err
    );

    modport slave (
        input  adr, data_in, size, MEM_R_EN, MEM_W_EN,
        output DATA, ready, err
    );
endinterface

// File: rtl/data_mem_ws.sv
// Byte-addressable big-endian data memory with programmable wait states,
// a one-cycle ready/err completion pulse and range/alignment checking.
module data_mem_ws #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_BYTES = 1024,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic          clk,
    input  logic          rst,
    data_mem_ws_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH_BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [31:0]       din_q, din_d;
    logic [1:0]        size_q, size_d;
    logic              rd_q, rd_d;
    logic [31:0]       data_q, data_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;

    logic [7:0]        mem_q [DEPTH_BYTES];

    logic [ADDR_W-1:0] offset_s;
    logic [ADDR_W:0]   end_s;
    logic [2:0]        nbytes_s;
    logic              bad_s;
    logic              req_s;
    logic              access_s;
    logic              we_s;
    logic [IDX_W-1:0]  i0_s, i1_s, i2_s, i3_s;

    assign req_s = bus.MEM_R_EN | bus.MEM_W_EN;

    // Address decode and legality checks on the latched request.
    always_comb begin
        offset_s = adr_q - ADDR_W'(BASE_ADDR);
        case (size_q)
            2'b00:   nbytes_s = 3'd1;
            2'b01:   nbytes_s = 3'd2;
            default: nbytes_s = 3'd4;
        endcase
        // One extra bit keeps wrapped (below-base) offsets from overflowing back in range.
        end_s = {1'b0, offset_s} + (ADDR_W + 1)'(nbytes_s);
        bad_s = (size_q == 2'b11)
              || ((size_q == 2'b01) && (offset_s[0] != 1'b0))
              || ((size_q == 2'b10) && (offset_s[1:0] != 2'b00))
              || (end_s > (ADDR_W + 1)'(DEPTH_BYTES));
        i0_s = offset_s[IDX_W-1:0];
        i1_s = i0_s + IDX_W'(1);
        i2_s = i0_s + IDX_W'(2);
        i3_s = i0_s + IDX_W'(3);
        access_s = (state_q == S_WAIT) && (cnt_q == 8'd0);
        we_s     = access_s && !rd_q && !bad_s;
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            adr_q   <= '0;
            din_q   <= 32'd0;
            size_q  <= 2'b00;
            rd_q    <= 1'b0;
            data_q  <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            din_q   <= din_d;
            size_q  <= size_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; requests are only accepted in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_s) state_d = S_WAIT;
                else       state_d = S_IDLE;
            end
            S_WAIT: begin
                if (cnt_q == 8'd0) state_d = S_DONE;
                else               state_d = S_WAIT;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture and wait counter.
    always_comb begin
        cnt_d  = cnt_q;
        adr_d  = adr_q;
        din_d  = din_q;
        size_d = size_q;
        rd_d   = rd_q;
        if ((state_q == S_IDLE) && req_s) begin
            cnt_d  = 8'(WAIT_CYCLES);
            adr_d  = bus.adr;
            din_d  = bus.data_in;
            size_d = bus.size;
            rd_d   = bus.MEM_R_EN;
        end else if ((state_q == S_WAIT) && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Completion pulse and read data, produced at the access edge.
    always_comb begin
        ready_d = access_s;
        err_d   = access_s && bad_s;
        data_d  = data_q;
        if (access_s && rd_q && !bad_s) begin
            case (size_q)
                2'b00:   data_d = {24'd0, mem_q[i0_s]};
                2'b01:   data_d = {16'd0, mem_q[i0_s], mem_q[i1_s]};
                default: data_d = {mem_q[i0_s], mem_q[i1_s], mem_q[i2_s], mem_q[i3_s]};
            endcase
        end else begin
            data_d = data_q;
        end
    end

    // Big-endian byte-lane writes; the storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            case (size_q)
                2'b00: mem_q[i0_s] <= din_q[7:0];
                2'b01: begin
                    mem_q[i0_s] <= din_q[15:8];
                    mem_q[i1_s] <= din_q[7:0];
                end
                default: begin
                    mem_q[i0_s] <= din_q[31:24];
                    mem_q[i1_s] <= din_q[23:16];
                    mem_q[i2_s] <= din_q[15:8];
                    mem_q[i3_s] <= din_q[7:0];
                end
            endcase
        end
    end

    assign bus.DATA  = data_q;
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_data_mem_ws.sv
// Scoreboard bench: two memories (2 wait states and 0 wait states) driven by
// directed requests; monitors pop expected responses whenever ready pulses.
module tb_data_mem_ws;
    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea;
    exp_t eb;

    data_mem_ws_if #(.ADDR_W(32)) bus_a ();
    data_mem_ws_if #(.ADDR_W(32)) bus_b ();

    data_mem_ws #(.ADDR_W(32), .DEPTH_BYTES(1024), .BASE_ADDR(1024), .WAIT_CYCLES(2))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    data_mem_ws #(.ADDR_W(32), .DEPTH_BYTES(1024), .BASE_ADDR(1024), .WAIT_CYCLES(0))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor for the 2-wait-state memory.
    always @(negedge clk) begin
        if (!rst && bus_a.ready === 1'b1) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_ready_a: got ready=1 expected no response (cycle %0d)", cyc);
            end else begin
                ea = q_a.pop_front();
                chk("data_a", bus_a.DATA, ea.data);
                chk("err_a", {31'd0, bus_a.err}, {31'd0, ea.err});
                chk("ready_cycle_a", cyc, ea.cyc);
            end
        end
    end

    // Monitor for the 0-wait-state memory.
    always @(negedge clk) begin
        if (!rst && bus_b.ready === 1'b1) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_ready_b: got ready=1 expected no response (cycle %0d)", cyc);
            end else begin
                eb = q_b.pop_front();
                chk("data_b", bus_b.DATA, eb.data);
                chk("err_b", {31'd0, bus_b.err}, {31'd0, eb.err});
                chk("ready_cycle_b", cyc, eb.cyc);
            end
        end
    end

    task automatic req(input int sel, input logic r, input logic w, input logic [31:0] a,
                       input logic [1:0] sz, input logic [31:0] d,
                       input logic [31:0] exp_d, input logic exp_e);
        exp_t e;
        int   k;
        @(posedge clk);
        #1;
        e.data = exp_d;
        e.err  = exp_e;
        if (sel == 1) begin
            bus_b.adr = a; bus_b.data_in = d; bus_b.size = sz;
            bus_b.MEM_R_EN = r; bus_b.MEM_W_EN = w;
            e.cyc = cyc + 2;
            q_b.push_back(e);
        end else begin
            bus_a.adr = a; bus_a.data_in = d; bus_a.size = sz;
            bus_a.MEM_R_EN = r; bus_a.MEM_W_EN = w;
            e.cyc = cyc + 4;
            q_a.push_back(e);
        end
        @(posedge clk);
        #1;
        // Scramble inputs after the sampling edge; they must have no effect.
        if (sel == 1) begin
            bus_b.MEM_R_EN = 1'b0; bus_b.MEM_W_EN = 1'b0;
            bus_b.adr = 32'h0000_0404; bus_b.data_in = 32'h5A5A_5A5A; bus_b.size = 2'b11;
        end else begin
            bus_a.MEM_R_EN = 1'b0; bus_a.MEM_W_EN = 1'b0;
            bus_a.adr = 32'h0000_0404; bus_a.data_in = 32'h5A5A_5A5A; bus_a.size = 2'b11;
        end
        k = 0;
        while (k < 20 && ((sel == 1) ? q_b.size() : q_a.size()) != 0) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (((sel == 1) ? q_b.size() : q_a.size()) != 0) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got no ready expected ready within 20 cycles (adr 0x%08h)", a);
            if (sel == 1) q_b.delete();
            else          q_a.delete();
        end
    endtask

    initial begin
        cyc = 0; checks = 0; errors = 0;
        rst = 1'b1;
        bus_a.adr = 32'd0; bus_a.data_in = 32'd0; bus_a.size = 2'b00;
        bus_a.MEM_R_EN = 1'b0; bus_a.MEM_W_EN = 1'b0;
        bus_b.adr = 32'd0; bus_b.data_in = 32'd0; bus_b.size = 2'b00;
        bus_b.MEM_R_EN = 1'b0; bus_b.MEM_W_EN = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_data_a", bus_a.DATA, 32'd0);
        chk("reset_ready_a", {31'd0, bus_a.ready}, 32'd0);
        chk("reset_err_a", {31'd0, bus_a.err}, 32'd0);
        chk("reset_data_b", bus_b.DATA, 32'd0);

        // Word and sub-word traffic
        req(0, 1'b0, 1'b1, 32'd1024, 2'b10, 32'h1122_3344, 32'h0000_0000, 1'b0);
        req(0, 1'b1, 1'b0, 32'd1024, 2'b10, 32'h0,         32'h1122_3344, 1'b0);
        req(0, 1'b1, 1'b0, 32'd1025, 2'b00, 32'h0,         32'h0000_0022, 1'b0);
        req(0, 1'b0, 1'b1, 32'd1026, 2'b01, 32'h0000_AABB, 32'h0000_0022, 1'b0);
        req(0, 1'b1, 1'b0, 32'd1024, 2'b10, 32'h0,         32'h1122_AABB, 1'b0);
        // Misaligned and illegal size
        req(0, 1'b1, 1'b0, 32'd1026, 2'b10, 32'h0,         32'h1122_AABB, 1'b1);
        req(0, 1'b0, 1'b1, 32'd1025, 2'b01, 32'h0000_1234, 32'h1122_AABB, 1'b1);
        req(0, 1'b1, 1'b0, 32'd1024, 2'b11, 32'h0,         32'h1122_AABB, 1'b1);
        req(0, 1'b1, 1'b0, 32'd1024, 2'b10, 32'h0,         32'h1122_AABB, 1'b0);
        // Range boundaries
        req(0, 1'b0, 1'b1, 32'd2044, 2'b10, 32'h5566_7788, 32'h1122_AABB, 1'b0);
        req(0, 1'b1, 1'b0, 32'd2044, 2'b10, 32'h0,         32'h5566_7788, 1'b0);
        req(0, 1'b1, 1'b0, 32'd2046, 2'b10, 32'h0,         32'h5566_7788, 1'b1);
        req(0, 1'b1, 1'b0, 32'd2048, 2'b00, 32'h0,         32'h5566_7788, 1'b1);
        req(0, 1'b1, 1'b0, 32'd1020, 2'b10, 32'h0,         32'h5566_7788, 1'b1);
        req(0, 1'b0, 1'b1, 32'd1020, 2'b10, 32'hFFFF_FFFF, 32'h5566_7788, 1'b1);
        req(0, 1'b0, 1'b1, 32'd2048, 2'b00, 32'h0000_0099, 32'h5566_7788, 1'b1);
        req(0, 1'b1, 1'b0, 32'd2044, 2'b10, 32'h0,         32'h5566_7788, 1'b0);
        // Read wins over write when both are requested
        req(0, 1'b1, 1'b1, 32'd1024, 2'b10, 32'hDEAD_BEEF, 32'h1122_AABB, 1'b0);
        req(0, 1'b1, 1'b0, 32'd1024, 2'b10, 32'h0,         32'h1122_AABB, 1'b0);
        req(0, 1'b0, 1'b1, 32'd1028, 2'b10, 32'h0102_0304, 32'h1122_AABB, 1'b0);

        // Reset during WAIT aborts a pending write
        @(posedge clk);
        #1;
        bus_a.adr = 32'd1028; bus_a.data_in = 32'hCAFE_F00D; bus_a.size = 2'b10;
        bus_a.MEM_W_EN = 1'b1;
        @(posedge clk);
        #1;
        bus_a.MEM_W_EN = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midop_reset_data", bus_a.DATA, 32'd0);
        chk("midop_reset_ready", {31'd0, bus_a.ready}, 32'd0);
        chk("midop_reset_err", {31'd0, bus_a.err}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        req(0, 1'b1, 1'b0, 32'd1028, 2'b10, 32'h0,         32'h0102_0304, 1'b0);

        // Zero wait states
        req(1, 1'b0, 1'b1, 32'd1024, 2'b10, 32'h0A0B_0C0D, 32'h0000_0000, 1'b0);
        req(1, 1'b1, 1'b0, 32'd1024, 2'b10, 32'h0,         32'h0A0B_0C0D, 1'b0);
        req(1, 1'b1, 1'b0, 32'd1027, 2'b00, 32'h0,         32'h0000_000D, 1'b0);
        req(1, 1'b1, 1'b0, 32'd1026, 2'b01, 32'h0,         32'h0000_0C0D, 1'b0);

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
